// File: rtl/spi_shared_master_if.sv
// spi_shared_master_if
//   Bundles the request/response handshake and the shared SPI pins of
//   spi_shared_master. Per-device fields are packed [N_DEV-1:0][...] arrays,
//   bit-compatible with a flat N_DEV*W vector (device 0 in the low bits).
//
//   I_div        per-device half-period divider, H_d = I_div[d] + 1 clocks
//   I_req_valid  per-device byte request valid
//   I_req_data   per-device byte to send
//   I_req_last   byte closes the transaction (CS released afterwards)
//   O_req_ready  per-device accept (one-hot or zero)
//   O_rsp_valid  one-cycle pulse: received byte available
//   O_rsp_dev    device index of the response
//   O_rsp_data   byte sampled from MISO
//   O_sclk       shared SCLK (idles low)
//   O_mosi       shared MOSI (idles high)
//   I_miso       shared MISO
//   O_cs_n       active-low chip selects
//   O_busy       master not idle
//
//   modport master: the SPI master block; modport slave: its client/bus side.
interface spi_shared_master_if #(
    parameter int N_DEV  = 2,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8,
    parameter int DEV_W  = (N_DEV > 1) ? $clog2(N_DEV) : 1
);
    logic [N_DEV-1:0][DIV_W-1:0]  I_div;
    logic [N_DEV-1:0]             I_req_valid;
    logic [N_DEV-1:0][DATA_W-1:0] I_req_data;
    logic [N_DEV-1:0]             I_req_last;
    logic [N_DEV-1:0]             O_req_ready;
    logic                         O_rsp_valid;
    logic [DEV_W-1:0]             O_rsp_dev;
    logic [DATA_W-1:0]            O_rsp_data;
    logic                         O_sclk;
    logic                         O_mosi;
    logic                         I_miso;
    logic [N_DEV-1:0]             O_cs_n;
    logic                         O_busy;

    modport master (
        input  I_div, I_req_valid, I_req_data, I_req_last, I_miso,
        output O_req_ready, O_rsp_valid, O_rsp_dev, O_rsp_data,
               O_sclk, O_mosi, O_cs_n, O_busy
    );

    modport slave (
        output I_div, I_req_valid, I_req_data, I_req_last, I_miso,
        input  O_req_ready, O_rsp_valid, O_rsp_dev, O_rsp_data,
               O_sclk, O_mosi, O_cs_n, O_busy
    );
endinterface

// File: rtl/spi_shared_master.sv
// spi_shared_master
//   Mode-0, MSB-first SPI master time-sharing one SCLK/MOSI/MISO bus among
//   N_DEV chip-selected slaves. Round-robin grant in IDLE; the granted device
//   keeps the bus (CS low) until it sends a byte flagged last. Each byte uses
//   the divider of its device, latched when the byte is accepted.
//
//   Ports:
//     I_clk  system clock
//     I_rst  synchronous active-high reset
//     bus    spi_shared_master_if.master (requests, responses, SPI pins)
module spi_shared_master #(
    parameter int N_DEV  = 2,
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    spi_shared_master_if.master   bus
);
    localparam int DEV_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_HIGH, S_LOW, S_WAIT, S_HOLD, S_RELEASE
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;      // cycles spent in current phase
    logic [DIV_W-1:0]   div_q, div_d;      // latched H-1 for current byte
    logic [BIT_W-1:0]   bit_q, bit_d;      // bits already sampled
    logic [DATA_W-1:0]  tx_q, tx_d;        // MSB drives MOSI
    logic [DATA_W-1:0]  rx_q, rx_d;
    logic               last_q, last_d;
    logic [DEV_W-1:0]   gnt_q, gnt_d;
    logic [DEV_W-1:0]   rr_q, rr_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DEV_W-1:0]   rsp_dev_q, rsp_dev_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    // Round-robin search starting at rr_q with wrap.
    logic               arb_hit;
    logic [DEV_W-1:0]   arb_idx;
    int                 idx;

    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        idx     = 0;
        for (int i = 0; i < N_DEV; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= N_DEV) idx = idx - N_DEV;
            if (!arb_hit && bus.I_req_valid[DEV_W'(idx)]) begin
                arb_hit = 1'b1;
                arb_idx = DEV_W'(idx);
            end
        end
    end

    logic               phase_end;
    logic               bit_last;
    logic [N_DEV-1:0]   ready;
    logic               accept;
    logic [DEV_W-1:0]   acc_dev;
    logic [N_DEV-1:0]   cs_n;
    logic               sclk;
    logic               mosi;
    logic [DATA_W-1:0]  rx_shift;

    assign phase_end = (cnt_q == div_q);
    assign bit_last  = (bit_q == BIT_W'(DATA_W - 1));
    assign rx_shift  = DATA_W'({rx_q, bus.I_miso});

    // While locked (WAIT) only the owner is offered ready, unconditionally.
    always_comb begin
        ready   = '0;
        acc_dev = arb_idx;
        if (state_q == S_IDLE && arb_hit) begin
            ready[arb_idx] = 1'b1;
        end else if (state_q == S_WAIT) begin
            ready[gnt_q] = 1'b1;
            acc_dev      = gnt_q;
        end
    end

    assign accept = |(ready & bus.I_req_valid);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        rsp_valid_d = 1'b0;
        rsp_dev_d   = rsp_dev_q;
        rsp_data_d  = rsp_data_q;
        cs_n        = '1;
        sclk        = 1'b0;
        mosi        = 1'b1;

        // Timed phases count 0..div_q, then the counter restarts.
        cnt_d = phase_end ? '0 : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_SETUP: begin
                cs_n[gnt_q] = 1'b0;
                mosi        = tx_q[DATA_W-1];
                if (phase_end) state_d = S_HIGH;
            end
            S_HIGH: begin
                cs_n[gnt_q] = 1'b0;
                sclk        = 1'b1;
                mosi        = tx_q[DATA_W-1];
                if (phase_end) begin
                    rx_d = rx_shift;
                    if (bit_last) begin
                        rsp_valid_d = 1'b1;
                        rsp_dev_d   = gnt_q;
                        rsp_data_d  = rx_shift;
                        state_d     = last_q ? S_HOLD : S_WAIT;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        tx_d    = tx_q << 1;
                        state_d = S_LOW;
                    end
                end
            end
            S_LOW: begin
                cs_n[gnt_q] = 1'b0;
                mosi        = tx_q[DATA_W-1];
                if (phase_end) state_d = S_HIGH;
            end
            S_WAIT: begin
                // MOSI keeps the final bit of the previous byte.
                cs_n[gnt_q] = 1'b0;
                mosi        = tx_q[DATA_W-1];
                cnt_d       = '0;
            end
            S_HOLD: begin
                cs_n[gnt_q] = 1'b0;
                mosi        = tx_q[DATA_W-1];
                if (phase_end) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (phase_end) begin
                    state_d = S_IDLE;
                    rr_d    = (gnt_q == DEV_W'(N_DEV - 1)) ? '0 : gnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Accept from IDLE (new grant) or WAIT (locked owner).
        if (accept) begin
            gnt_d   = acc_dev;
            tx_d    = bus.I_req_data[acc_dev];
            last_d  = bus.I_req_last[acc_dev];
            div_d   = bus.I_div[acc_dev];
            cnt_d   = '0;
            bit_d   = '0;
            state_d = S_SETUP;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            div_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            last_q      <= 1'b0;
            gnt_q       <= '0;
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dev_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dev_q   <= rsp_dev_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign bus.O_req_ready = ready;
    assign bus.O_rsp_valid = rsp_valid_q;
    assign bus.O_rsp_dev   = rsp_dev_q;
    assign bus.O_rsp_data  = rsp_data_q;
    assign bus.O_sclk      = sclk;
    assign bus.O_mosi      = mosi;
    assign bus.O_cs_n      = cs_n;
    assign bus.O_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_shared_master.sv
// tb_spi_shared_master
//   Directed bench for spi_shared_master with N_DEV=3. Inputs change and
//   outputs are sampled 1 time unit after the falling clock edge. Cycle stamps
//   are indices of the last rising edge, so a byte accepted at edge t shows
//   its response after edge t+16H.
module tb_spi_shared_master;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_shared_master_if #(.N_DEV(N), .DATA_W(W), .DIV_W(DW)) bus ();

    spi_shared_master #(.N_DEV(N), .DATA_W(W), .DIV_W(DW)) dut (
        .I_clk (clk),
        .I_rst (rst),
        .bus   (bus.master)
    );

    logic [N-1:0]         tv, auto_en, tlast;
    logic [N-1:0][W-1:0]  tdata;
    logic [N-1:0][DW-1:0] div;
    int                   miso_mode;
    logic [W-1:0]         pat;
    logic                 miso_pat;
    logic                 lock_win;

    assign bus.I_req_valid = tv | auto_en;
    assign bus.I_req_data  = tdata;
    assign bus.I_req_last  = tlast | auto_en;
    assign bus.I_div       = div;
    assign bus.I_miso      = (miso_mode == 0) ? bus.O_mosi :
                             (miso_mode == 1) ? 1'b1 : miso_pat;

    // Monitor state
    int   cyc = 0;
    int   rises = 0, nrise = 0, nhi = 0, hi_cnt = 0, last_hi = 0;
    int   cs0_low = 0, cs1_rise = 0, lock_bad = 0, bad_cs = 0, bad_sclk = 0;
    logic sclk_prev = 1'b0, cs1_prev = 1'b1;
    int   gq[$];
    int   rq_t[$], rq_dev[$], rq_data[$];

    always_comb miso_pat = (rises >= 1 && rises <= W) ? pat[W-rises] : 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst)
            for (int d = 0; d < N; d++)
                if (bus.I_req_valid[d] && bus.O_req_ready[d]) gq.push_back(d);
    end

    always @(negedge clk) begin
        if (bus.O_rsp_valid) begin
            rq_t.push_back(cyc);
            rq_dev.push_back(int'(bus.O_rsp_dev));
            rq_data.push_back(int'(bus.O_rsp_data));
        end
        sclk_prev <= bus.O_sclk;
        cs1_prev  <= bus.O_cs_n[1];
        rises     <= (&bus.O_cs_n) ? 0 : ((bus.O_sclk && !sclk_prev) ? rises + 1 : rises);
        nrise     <= nrise + ((bus.O_sclk && !sclk_prev) ? 1 : 0);
        nhi       <= nhi + (bus.O_sclk ? 1 : 0);
        hi_cnt    <= bus.O_sclk ? hi_cnt + 1 : 0;
        last_hi   <= (!bus.O_sclk && sclk_prev) ? hi_cnt : last_hi;
        cs0_low   <= cs0_low + (bus.O_cs_n[0] ? 0 : 1);
        cs1_rise  <= cs1_rise + ((lock_win && bus.O_cs_n[1] && !cs1_prev) ? 1 : 0);
        lock_bad  <= lock_bad + ((lock_win && bus.O_busy && bus.O_req_ready[0]) ? 1 : 0);
        bad_cs    <= bad_cs + (($countones(~bus.O_cs_n) > 1) ? 1 : 0);
        bad_sclk  <= bad_sclk + ((bus.O_sclk && (&bus.O_cs_n)) ? 1 : 0);
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Present a byte on device d and return the edge index of its accept.
    task automatic send(input int d, input logic [W-1:0] data, input logic last, output int t);
        int n = 0;
        tv[d] = 1'b1; tdata[d] = data; tlast[d] = last;
        #1;
        while (!bus.O_req_ready[d] && n < 5000) begin tick(); n++; end
        chk("send_ready", bus.O_req_ready[d], 1'b1);
        @(posedge clk);
        #1;
        t = cyc;
        tv[d] = 1'b0;
    endtask

    task automatic wait_rsp(output int t, output int dev, output int data);
        int n = 0;
        while (rq_t.size() == 0 && n < 5000) begin tick(); n++; end
        chk("rsp_seen", rq_t.size() > 0, 1'b1);
        if (rq_t.size() > 0) begin
            t = rq_t.pop_front(); dev = rq_dev.pop_front(); data = rq_data.pop_front();
        end else begin
            t = -1; dev = -1; data = -1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.O_busy && n < 5000) begin tick(); n++; end
        chk("idle", bus.O_busy, 1'b0);
    endtask

    task automatic wait_grants(input int k);
        int n = 0;
        while (gq.size() < k && n < 2000) begin tick(); n++; end
        chk("grant_cnt", gq.size() >= k, 1'b1);
    endtask

    initial begin
        int t, t2, rt, rd, rv, n;
        int s_cs0, s_rise, s_hi, s_cs1, s_lb;
        logic [W-1:0] exp_b [3];
        tv = '0; auto_en = '0; tlast = '0; tdata = '0; div = '0;
        miso_mode = 0; pat = '0; lock_win = 1'b0;

        // Reset values
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_cs_n", bus.O_cs_n, 3'b111);
        chk("rst_sclk", bus.O_sclk, 1'b0);
        chk("rst_mosi", bus.O_mosi, 1'b1);
        chk("rst_ready", bus.O_req_ready, 3'b000);
        chk("rst_rspv", bus.O_rsp_valid, 1'b0);
        chk("rst_rspdev", bus.O_rsp_dev, 0);
        chk("rst_rspdat", bus.O_rsp_data, 0);
        chk("rst_busy", bus.O_busy, 1'b0);
        rst = 1'b0;
        tick();

        // Single byte, dev 0, H=1, loopback 0xA5
        s_cs0 = cs0_low; s_rise = nrise; s_hi = nhi;
        send(0, 8'hA5, 1'b1, t);
        wait_rsp(rt, rd, rv);
        chk("b1_rsp_time", rt - t, 16);
        chk("b1_rsp_dev", rd, 0);
        chk("b1_rsp_data", rv, 8'hA5);
        tv[0] = 1'b1; tdata[0] = 8'h5A; tlast[0] = 1'b1;
        #1;
        n = 0;
        while (!bus.O_req_ready[0] && n < 100) begin tick(); n++; end
        chk("b1_next_ready", cyc - t, 18);
        chk("b1_cs_low", cs0_low - s_cs0, 17);
        chk("b1_rises", nrise - s_rise, 8);
        chk("b1_sclk_hi", nhi - s_hi, 8);
        send(0, 8'h5A, 1'b1, t2);
        chk("b1_next_acc", t2 - t, 19);
        wait_rsp(rt, rd, rv);
        chk("b2_rsp_data", rv, 8'h5A);
        wait_idle();

        // Locked 3-byte transaction on dev 1 with dev 0 always valid
        gq.delete();
        tdata[0] = 8'h77;
        auto_en[0] = 1'b1;
        s_cs1 = cs1_rise; s_lb = lock_bad;
        lock_win = 1'b1;
        send(1, 8'h01, 1'b0, t);
        send(1, 8'h02, 1'b0, t2);
        chk("lk_wait_acc", t2 - t, 17);
        send(1, 8'h03, 1'b1, t);
        wait_idle();
        lock_win = 1'b0;
        exp_b[0] = 8'h01; exp_b[1] = 8'h02; exp_b[2] = 8'h03;
        for (int i = 0; i < 3; i++) begin
            wait_rsp(rt, rd, rv);
            chk("lk_rsp_dev", rd, 1);
            chk("lk_rsp_data", rv, exp_b[i]);
        end
        chk("lk_cs1_rise", cs1_rise - s_cs1, 1);
        chk("lk_ready0", lock_bad - s_lb, 0);
        wait_grants(4);
        auto_en[0] = 1'b0;
        chk("lk_gnt0", gq[0], 1);
        chk("lk_gnt2", gq[2], 1);
        chk("lk_gnt3", gq[3], 0);
        wait_idle();
        repeat (2) tick();
        rq_t.delete(); rq_dev.delete(); rq_data.delete();

        // MISO tied 1, then MISO pattern 1,0,0,0,0,0,0,0
        miso_mode = 1;
        send(0, 8'h00, 1'b1, t);
        wait_rsp(rt, rd, rv);
        chk("miso_ones", rv, 8'hFF);
        wait_idle();
        repeat (2) tick();
        miso_mode = 2; pat = 8'h80;
        send(0, 8'h00, 1'b1, t);
        wait_rsp(rt, rd, rv);
        chk("miso_pat", rv, 8'h80);
        wait_idle();
        repeat (2) tick();
        miso_mode = 0;

        // Reset during HIGH of bit 3
        send(1, 8'hC3, 1'b1, t);
        n = 0;
        while (!(rises == 4 && bus.O_sclk) && n < 100) begin tick(); n++; end
        chk("rs_in_bit3", bus.O_sclk, 1'b1);
        rst = 1'b1;
        tick();
        chk("rs_cs_n", bus.O_cs_n, 3'b111);
        chk("rs_sclk", bus.O_sclk, 1'b0);
        chk("rs_mosi", bus.O_mosi, 1'b1);
        chk("rs_rspv", bus.O_rsp_valid, 1'b0);
        chk("rs_busy", bus.O_busy, 1'b0);
        rst = 1'b0;
        repeat (20) tick();
        chk("rs_no_rsp", rq_t.size(), 0);

        // RR wrap with all three valid: 0,1,2,0
        gq.delete();
        tdata[0] = 8'h10; tdata[1] = 8'h11; tdata[2] = 8'h12;
        auto_en = 3'b111;
        wait_grants(4);
        auto_en = 3'b000;
        chk("rr3_g0", gq[0], 0);
        chk("rr3_g1", gq[1], 1);
        chk("rr3_g2", gq[2], 2);
        chk("rr3_g3", gq[3], 0);
        wait_idle();
        repeat (2) tick();

        // Two devices valid after reset: 0,1,0,1
        rst = 1'b1; tick(); rst = 1'b0; tick();
        gq.delete();
        auto_en = 3'b011;
        wait_grants(4);
        auto_en = 3'b000;
        chk("rr2_g0", gq[0], 0);
        chk("rr2_g1", gq[1], 1);
        chk("rr2_g2", gq[2], 0);
        chk("rr2_g3", gq[3], 1);
        wait_idle();
        repeat (2) tick();
        rq_t.delete(); rq_dev.delete(); rq_data.delete();

        // Slow divider on dev 1 (H=67), divider changed mid-byte
        div[1] = 8'd66;
        send(1, 8'h3C, 1'b1, t);
        repeat (100) tick();
        div[1] = 8'd3;
        wait_rsp(rt, rd, rv);
        chk("div_rsp_time", rt - t, 16 * 67);
        chk("div_hi_width", last_hi, 67);
        chk("div_rsp_data", rv, 8'h3C);
        wait_idle();
        div[1] = 8'd0;

        chk("one_cs_low", bad_cs, 0);
        chk("sclk_cs_high", bad_sclk, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
